// File: rtl/cp_gpp_port.sv
// cp_gpp_port: endpoint between the photonic network interface and the GPP.
// It buffers inbound network words for the GPP in an RX FIFO, buffers GPP
// transmit words in a TX FIFO, and drains the TX FIFO through a one-word
// output register onto a valid/ready stream.
//
// TX output stage states:
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_EMPTY | output register holds nothing, net_tx_valid low
//   S_FULL  | output register holds a word, net_tx_valid high
module cp_gpp_port #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_rtr,
  input  logic        gpp_rtr_cp,
  input  logic        gpp_rtr_dp,
  input  logic        gpp_trf_dp,
  input  logic [15:0] gpp_tx_data,
  output logic [15:0] RAM_rx_data_out,
  output logic        data_rx_flag,
  output logic        gpp_trf_cp,
  input  logic [15:0] net_rx_data,
  input  logic        net_rx_valid,
  output logic        net_rx_ready,
  output logic [15:0] net_tx_data,
  output logic        net_tx_valid,
  input  logic        net_tx_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [15:0]   rx_mem [DEPTH];
  logic [AW-1:0] rx_wptr, rx_rptr;
  logic [CW-1:0] rx_count;

  logic [15:0]   tx_mem [DEPTH];
  logic [AW-1:0] tx_wptr, tx_rptr;
  logic [CW-1:0] tx_count;

  logic [0:0]    state;
  logic          tx_overflow, rx_underflow;

  logic rd, st, wr;
  logic rx_full, rx_empty, tx_full, tx_empty;
  logic rx_push, rx_pop, tx_push, tx_pop;
  logic ovf_evt, unf_evt;
  logic [15:0] status_word;

  // GPP strobe qualification; a status request overrides a read
  always_comb begin
    rd = enable_rtr & gpp_rtr_cp & ~gpp_rtr_dp;
    st = enable_rtr & gpp_rtr_dp;
    wr = enable_rtr & gpp_trf_dp;
  end

  // FIFO flags and transfer conditions, all from registered counts
  always_comb begin
    rx_full  = (rx_count == FULL_CNT);
    rx_empty = (rx_count == '0);
    tx_full  = (tx_count == FULL_CNT);
    tx_empty = (tx_count == '0);
    rx_push  = net_rx_valid & ~rx_full;
    rx_pop   = rd & ~rx_empty;
    unf_evt  = rd & rx_empty;
    tx_push  = wr & ~tx_full;
    ovf_evt  = wr & tx_full;
    // the output stage takes a word whenever its register is free or being drained
    tx_pop   = ~tx_empty & ((state == S_EMPTY) | net_tx_ready);
  end

  // Status word and GPP read-data mux
  always_comb begin
    status_word = {tx_overflow, rx_underflow, 7'(rx_count), 7'(FULL_CNT - tx_count)};
    if (st)
      RAM_rx_data_out = status_word;
    else if (!rx_empty)
      RAM_rx_data_out = rx_mem[rx_rptr];
    else
      RAM_rx_data_out = 16'h0000;
  end

  // Registered-state flags towards the GPP and the network
  always_comb begin
    data_rx_flag = ~rx_empty;
    gpp_trf_cp   = ~tx_full;
    net_rx_ready = ~rx_full;
    net_tx_valid = (state == S_FULL);
  end

  // RX storage write port (contents are don't-care while the count is zero)
  always_ff @(posedge clk) begin
    if (rx_push)
      rx_mem[rx_wptr] <= net_rx_data;
  end

  // RX pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
      if (rx_pop)  rx_rptr <= rx_rptr + PTR_ONE;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CNT_ONE;
        2'b01:   rx_count <= rx_count - CNT_ONE;
        default: rx_count <= rx_count;
      endcase
    end
  end

  // TX storage write port
  always_ff @(posedge clk) begin
    if (tx_push)
      tx_mem[tx_wptr] <= gpp_tx_data;
  end

  // TX pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
      if (tx_pop)  tx_rptr <= tx_rptr + PTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CNT_ONE;
        2'b01:   tx_count <= tx_count - CNT_ONE;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // TX output stage: load from the FIFO head, hold until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_EMPTY;
      net_tx_data <= 16'h0000;
    end else if (tx_pop) begin
      net_tx_data <= tx_mem[tx_rptr];
      state       <= S_FULL;
    end else if ((state == S_FULL) && net_tx_ready) begin
      state       <= S_EMPTY;
    end
  end

  // Sticky error flags; a fresh event wins over a clearing status read
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      tx_overflow  <= (st ? 1'b0 : tx_overflow)  | ovf_evt;
      rx_underflow <= (st ? 1'b0 : rx_underflow) | unf_evt;
    end
  end

endmodule
